// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Loads a program into the instruction memory from a byte stream. Bytes
// arrive over a valid/ready handshake, are packed little-endian into
// WIDTH-bit words, and each finished word is written to the imem write port
// at consecutive addresses starting from 0. While a load runs the core is
// held in reset; core_nrst is released once the last word is written.
//
// Ports:
//   clk_in          clock
//   rst_in          synchronous, active-low reset
//   start_in        one-cycle pulse to begin a load (honoured only when idle)
//   len_in          number of words to load, 1..2**INDEX, sampled with start
//   byte_valid_in   stream byte valid
//   byte_data_in    stream byte
//   byte_ready_out  a byte is accepted this cycle when also valid
//   imem_we_out     imem write enable
//   imem_addr_out   imem word address (holds when not writing)
//   imem_data_out   imem write data (holds when not writing)
//   core_nrst_out   active-low core reset, 0 = core held
//   busy_out        load in progress
//   done_out        one-cycle pulse after the last word is written
//   err_out         one-cycle pulse when start carried an invalid length
//   checksum_out    XOR of all words written in the current or last load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int INDEX = 6
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [INDEX:0]   len_in,
    input  logic             byte_valid_in,
    input  logic [7:0]       byte_data_in,
    output logic             byte_ready_out,
    output logic             imem_we_out,
    output logic [INDEX-1:0] imem_addr_out,
    output logic [WIDTH-1:0] imem_data_out,
    output logic             core_nrst_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out,
    output logic [WIDTH-1:0] checksum_out
);

    localparam int BYTES = WIDTH / 8;
    localparam int DEPTH = 2 ** INDEX;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [INDEX:0] DEPTH_L   = (INDEX + 1)'(DEPTH);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [BCW-1:0]   bcnt_reg;      // byte position within the current word
    logic [INDEX-1:0] addr_reg;      // address of the word being assembled
    logic [INDEX-1:0] len_m1_reg;    // address of the final word of this load
    logic [WIDTH-1:0] asm_reg;       // partially assembled word
    logic [INDEX-1:0] addr_out_reg;  // captured write address
    logic [WIDTH-1:0] data_out_reg;  // captured write data
    logic [WIDTH-1:0] checksum_reg;
    logic             core_nrst_reg;
    logic             err_reg;

    logic             accept;
    logic             last_byte;
    logic             last_word;
    logic             len_ok;
    logic [WIDTH-1:0] word_next;

    assign accept    = byte_ready_out && byte_valid_in;
    assign last_byte = (bcnt_reg == LAST_BYTE);
    assign last_word = (addr_reg == len_m1_reg);
    assign len_ok    = (len_in != '0) && (len_in <= DEPTH_L);

    // Assembled word including the byte on the bus: only the lane selected
    // by the byte counter takes the new byte, other lanes keep their value.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign word_next[8*gi +: 8] = (bcnt_reg == BCW'(gi)) ? byte_data_in
                                                                 : asm_reg[8*gi +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_in && len_ok) state_next = RECV;
            RECV:    if (accept && last_byte) state_next = WRITE;
            WRITE:   state_next = last_word ? DONE : RECV;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        byte_ready_out = 1'b0;
        imem_we_out    = 1'b0;
        busy_out       = 1'b0;
        done_out       = 1'b0;
        case (state_reg)
            RECV: begin
                byte_ready_out = 1'b1;
                busy_out       = 1'b1;
            end
            WRITE: begin
                imem_we_out = 1'b1;
                busy_out    = 1'b1;
            end
            DONE:    done_out = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The write address/data are captured on the edge that takes
    // the last byte of a word, so the imem port only changes when a new word
    // is about to be written and otherwise holds its previous value.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bcnt_reg      <= '0;
            addr_reg      <= '0;
            len_m1_reg    <= '0;
            asm_reg       <= '0;
            addr_out_reg  <= '0;
            data_out_reg  <= '0;
            checksum_reg  <= '0;
            core_nrst_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_in) begin
                        if (len_ok) begin
                            // len_in is 1..DEPTH so len-1 always fits INDEX bits
                            len_m1_reg    <= INDEX'(len_in - 1'b1);
                            addr_reg      <= '0;
                            bcnt_reg      <= '0;
                            checksum_reg  <= '0;
                            core_nrst_reg <= 1'b0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        asm_reg <= word_next;
                        if (last_byte) begin
                            bcnt_reg     <= '0;
                            addr_out_reg <= addr_reg;
                            data_out_reg <= word_next;
                        end else begin
                            bcnt_reg <= bcnt_reg + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    checksum_reg <= checksum_reg ^ data_out_reg;
                    if (last_word) begin
                        // release lands on the DONE cycle
                        core_nrst_reg <= 1'b1;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr_out = addr_out_reg;
    assign imem_data_out = data_out_reg;
    assign checksum_out  = checksum_reg;
    assign core_nrst_out = core_nrst_reg;
    assign err_out       = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A behavioural model tracks the load
// in terms of bytes collected, words written and the running XOR, and the
// monitor compares every DUT output against it on each falling edge.
// Directed scenarios add literal expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int INDEX = 6;
    localparam int BYTES = WIDTH / 8;
    localparam int DEPTH = 2 ** INDEX;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start_in;
    logic [INDEX:0]   len_in;
    logic             byte_valid_in;
    logic [7:0]       byte_data_in;
    logic             byte_ready_out;
    logic             imem_we_out;
    logic [INDEX-1:0] imem_addr_out;
    logic [WIDTH-1:0] imem_data_out;
    logic             core_nrst_out;
    logic             busy_out;
    logic             done_out;
    logic             err_out;
    logic [WIDTH-1:0] checksum_out;

    always #5 clk_in = ~clk_in;

    imem_loader #(.WIDTH(WIDTH), .INDEX(INDEX)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .len_in         (len_in),
        .byte_valid_in  (byte_valid_in),
        .byte_data_in   (byte_data_in),
        .byte_ready_out (byte_ready_out),
        .imem_we_out    (imem_we_out),
        .imem_addr_out  (imem_addr_out),
        .imem_data_out  (imem_data_out),
        .core_nrst_out  (core_nrst_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .err_out        (err_out),
        .checksum_out   (checksum_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               model_on = 1'b0;
    bit               m_loading = 1'b0;
    int               m_len = 0;
    int               m_words = 0;
    logic [7:0]       m_bytes[$];
    bit               e_ready = 1'b0, e_we = 1'b0, e_busy = 1'b0;
    bit               e_done = 1'b0, e_err = 1'b0, e_nrst = 1'b0;
    logic [INDEX-1:0] e_addr = '0;
    logic [WIDTH-1:0] e_data = '0;
    logic [WIDTH-1:0] e_csum = '0;

    // DUT write log, filled by the monitor
    int               wr_total = 0;
    int               err_seen = 0;
    logic [INDEX-1:0] wr_addr_log[256];
    logic [WIDTH-1:0] wr_data_log[256];
    int               cyc = 0;

    always @(negedge clk_in) begin
        bit               n_we, n_done, n_err, idle_now;
        logic [WIDTH-1:0] word;
        if (model_on) begin
            check("byte_ready", 64'(byte_ready_out), 64'(e_ready));
            check("imem_we",    64'(imem_we_out),    64'(e_we));
            check("imem_addr",  64'(imem_addr_out),  64'(e_addr));
            check("imem_data",  64'(imem_data_out),  64'(e_data));
            check("busy",       64'(busy_out),       64'(e_busy));
            check("done",       64'(done_out),       64'(e_done));
            check("err",        64'(err_out),        64'(e_err));
            check("core_nrst",  64'(core_nrst_out),  64'(e_nrst));
            check("checksum",   64'(checksum_out),   64'(e_csum));
            if (imem_we_out === 1'b1) begin
                wr_addr_log[wr_total % 256] = imem_addr_out;
                wr_data_log[wr_total % 256] = imem_data_out;
                wr_total++;
                $display("cycle %0d write addr=%0d data=%h", cyc, imem_addr_out, imem_data_out);
            end
            if (err_out === 1'b1) begin
                err_seen++;
                $display("cycle %0d length error pulse", cyc);
            end
        end
        // advance the model with the inputs seen by the coming edge
        if (rst_in === 1'b0) begin
            model_on  = 1'b1;
            m_loading = 1'b0;
            m_bytes.delete();
            e_ready = 0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0; e_nrst = 0;
            e_addr  = '0; e_data = '0; e_csum = '0;
        end else if (model_on) begin
            n_we = 0; n_done = 0; n_err = 0;
            idle_now = !e_busy && !e_done;
            if (e_we) begin
                e_csum ^= e_data;
                m_words++;
                if (m_words == m_len) begin
                    n_done    = 1;
                    m_loading = 1'b0;
                    e_nrst    = 1'b1;
                end
            end
            if (e_ready && byte_valid_in) begin
                m_bytes.push_back(byte_data_in);
                if (m_bytes.size() == BYTES) begin
                    word = '0;
                    for (int k = 0; k < BYTES; k++)
                        word |= WIDTH'(m_bytes[k]) << (8 * k);
                    n_we   = 1;
                    e_addr = INDEX'(m_words);
                    e_data = word;
                    m_bytes.delete();
                end
            end
            if (idle_now && start_in) begin
                if (len_in >= 1 && int'(len_in) <= DEPTH) begin
                    m_loading = 1'b1;
                    m_len     = int'(len_in);
                    m_words   = 0;
                    e_csum    = '0;
                    e_nrst    = 1'b0;
                    m_bytes.delete();
                end else begin
                    n_err = 1;
                end
            end
            e_we    = n_we;
            e_done  = n_done;
            e_err   = n_err;
            e_busy  = m_loading;
            e_ready = m_loading && !n_we;
        end
        cyc++;
    end

    // ---------------- drivers ----------------
    task automatic start(input int len);
        @(posedge clk_in); #1;
        start_in = 1'b1;
        len_in   = (INDEX + 1)'(len);
        @(posedge clk_in); #1;
        start_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid_in = 1'b0;
        for (int i = 0; i < gap; i++) begin
            byte_data_in = 8'($urandom);
            @(posedge clk_in); #1;
        end
        byte_valid_in = 1'b1;
        byte_data_in  = b;
        n = 0;
        while (1) begin
            @(negedge clk_in);
            if (byte_ready_out === 1'b1) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL byte_accept_timeout actual=not_ready required=ready");
                break;
            end
        end
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int maxgap);
        for (int k = 0; k < BYTES; k++)
            send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (1) begin
            @(negedge clk_in);
            if (done_out === 1'b1) break;
            n++;
            if (n > bound) begin
                checks++; errors++;
                $display("FAIL wait_done_timeout actual=no_done required=done_pulse");
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int               base, errs0;
        int               len;
        bit               ordered;
        logic [WIDTH-1:0] w, xr;
        logic [WIDTH-1:0] words[DEPTH];

        rst_in        = 1'b0;
        start_in      = 1'b0;
        len_in        = '0;
        byte_valid_in = 1'b1;
        byte_data_in  = 8'hAA;

        // reset held two cycles with a valid byte on the bus
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("reset_ready",  64'(byte_ready_out), 64'd0);
        check("reset_nrst",   64'(core_nrst_out),  64'd0);
        check("reset_csum",   64'(checksum_out),   64'd0);
        check("reset_busy",   64'(busy_out),       64'd0);
        check("reset_we",     64'(imem_we_out),    64'd0);
        @(posedge clk_in); #1;
        rst_in        = 1'b1;
        byte_valid_in = 1'b0;
        idle_cycles(2);

        // single word
        base = wr_total;
        start(1);
        send_word(32'h00000013, 0);
        wait_done(20);
        check("single_count", 64'(wr_total - base), 64'd1);
        check("single_addr",  64'(wr_addr_log[base % 256]), 64'd0);
        check("single_data",  64'(wr_data_log[base % 256]), 64'h13);
        check("single_csum",  64'(checksum_out), 64'h13);
        check("single_nrst",  64'(core_nrst_out), 64'd1);

        // two words with gaps
        base = wr_total;
        start(2);
        send_word(32'h00100093, 3);
        send_word(32'h00200113, 3);
        wait_done(40);
        check("two_count", 64'(wr_total - base), 64'd2);
        check("two_data0", 64'(wr_data_log[base % 256]), 64'h00100093);
        check("two_data1", 64'(wr_data_log[(base + 1) % 256]), 64'h00200113);
        check("two_addr1", 64'(wr_addr_log[(base + 1) % 256]), 64'd1);
        check("two_csum",  64'(checksum_out), 64'h00300180);

        // invalid lengths
        base  = wr_total;
        errs0 = err_seen;
        start(0);
        idle_cycles(2);
        start(65);
        idle_cycles(3);
        @(negedge clk_in);
        check("inval_errs",   64'(err_seen - errs0), 64'd2);
        check("inval_writes", 64'(wr_total - base),  64'd0);
        check("inval_nrst",   64'(core_nrst_out),    64'd1);
        check("inval_csum",   64'(checksum_out),     64'h00300180);

        // full depth with a stray start mid-load
        base = wr_total;
        xr   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = WIDTH'($urandom);
            xr ^= words[i];
        end
        start(DEPTH);
        fork
            for (int i = 0; i < DEPTH; i++) send_word(words[i], 1);
            begin
                idle_cycles(100);
                start_in = 1'b1;
                len_in   = 7'd1;
                @(posedge clk_in); #1;
                start_in = 1'b0;
            end
        join
        wait_done(20);
        check("full_count", 64'(wr_total - base), 64'(DEPTH));
        ordered = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            if (wr_addr_log[(base + i) % 256] !== INDEX'(i) ||
                wr_data_log[(base + i) % 256] !== words[i]) ordered = 1'b0;
        check("full_order", 64'(ordered), 64'd1);
        check("full_last_addr", 64'(wr_addr_log[(base + DEPTH - 1) % 256]), 64'(DEPTH - 1));
        check("full_csum", 64'(checksum_out), 64'(xr));

        // reset after two words of a four-word load
        base = wr_total;
        start(4);
        send_word(32'h11223344, 1);
        send_word(32'h55667788, 1);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        idle_cycles(2);
        @(negedge clk_in);
        check("midrst_writes", 64'(wr_total - base), 64'd2);
        check("midrst_nrst",   64'(core_nrst_out), 64'd0);
        check("midrst_csum",   64'(checksum_out),  64'd0);
        check("midrst_busy",   64'(busy_out),      64'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        base = wr_total;
        w    = WIDTH'($urandom);
        start(1);
        send_word(w, 2);
        wait_done(30);
        check("after_rst_addr", 64'(wr_addr_log[base % 256]), 64'd0);
        check("after_rst_csum", 64'(checksum_out), 64'(w));

        // random loads with occasional bad starts
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                start(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DEPTH + 1, 2 * DEPTH - 1)));
                idle_cycles(1);
            end
            len  = $urandom_range(1, 8);
            base = wr_total;
            xr   = '0;
            start(len);
            for (int i = 0; i < len; i++) begin
                w = WIDTH'($urandom);
                xr ^= w;
                send_word(w, 3);
            end
            wait_done(20);
            check("rand_count", 64'(wr_total - base), 64'(len));
            check("rand_csum",  64'(checksum_out), 64'(xr));
            idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(3);
        @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
